// File: rtl/gray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gray_pkg                                                  |
// | Purpose  : Shared mode encodings and Gray/BCD helper functions.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package gray_pkg;

    // Widest word the helper functions accept; callers zero-extend into it.
    localparam int c_max_width = 64;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    function automatic logic [c_max_width-1:0] bin2gray(
        input logic [c_max_width-1:0] b,
        input int                     width
    );
        logic [c_max_width-1:0] m;
        m = '0;
        for (int i = 0; i < c_max_width; i++) begin
            if (i < width) begin
                m[i] = b[i];
            end
        end
        return m ^ (m >> 1);
    endfunction

    function automatic logic [c_max_width-1:0] gray2bin(
        input logic [c_max_width-1:0] g,
        input int                     width
    );
        logic [c_max_width-1:0] r;
        logic                   acc;
        r   = '0;
        acc = 1'b0;
        for (int i = c_max_width - 1; i >= 0; i--) begin
            if (i < width) begin
                acc  = acc ^ g[i];
                r[i] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_nibble_bad(input logic [3:0] n);
        return (n > 4'd9);
    endfunction

    function automatic logic bcd_word_bad(
        input logic [c_max_width-1:0] w,
        input int                     width
    );
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < c_max_width / 4; j++) begin
            if ((4 * j + 3) < width) begin
                bad = bad | bcd_nibble_bad(w[4*j +: 4]);
            end
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_codec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gray_codec_stage                                          |
// | Purpose  : One pipeline register of the Gray codec; resolves the     |
// |            Gray->binary bits SLICE_HI..SLICE_LO of the word.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module gray_codec_stage
    import gray_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHECK_BCD = 1,
    parameter int FIRST     = 1,
    parameter int LAST      = 1,
    parameter int SLICE_HI  = 7,
    parameter int SLICE_LO  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    output logic             out_valid,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    logic             r_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic [WIDTH-1:0] w_data;
    logic             w_err;

    // Gray->binary words carry resolved binary above SLICE_HI and raw Gray
    // below it, so bit i+1 is always already binary when bit i is resolved.
    always_comb begin
        w_data = in_data;
        if ((FIRST != 0) && (in_mode == MODE_B2G)) begin
            w_data = WIDTH'(bin2gray(c_max_width'(in_data), WIDTH));
        end
        if (in_mode == MODE_G2B) begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if ((i <= SLICE_HI) && (i >= SLICE_LO)) begin
                    w_data[i] = w_data[i+1] ^ w_data[i];
                end
            end
        end
    end

    always_comb begin
        w_err = in_err;
        if (CHECK_BCD != 0) begin
            if ((FIRST != 0) && (in_mode == MODE_B2G)) begin
                w_err = bcd_word_bad(c_max_width'(in_data), WIDTH);
            end
            if ((LAST != 0) && (in_mode == MODE_G2B)) begin
                w_err = bcd_word_bad(c_max_width'(w_data), WIDTH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= MODE_B2G;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (adv) begin
            r_valid <= in_valid;
            r_mode  <= in_mode;
            r_data  <= w_data;
            r_err   <= w_err;
        end
    end

    assign out_valid = r_valid;
    assign out_mode  = r_mode;
    assign out_data  = r_data;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gray_codec_pipe                                           |
// | Purpose  : Pipelined binary<->Gray converter with valid/ready and    |
// |            optional BCD digit check; STAGES cycles of latency.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter int CHECK_BCD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_err
);

    // Gray->binary bits resolved per stage, MSB slice first.
    localparam int c_chunk = (WIDTH + STAGES - 1) / STAGES;

    logic                         w_adv;
    logic [STAGES:0]              w_valid;
    logic [STAGES:0]              w_mode;
    logic [STAGES:0]              w_err;
    logic [STAGES:0][WIDTH-1:0]   w_data;

    // Bubbles are kept: the whole pipe moves together or not at all.
    assign w_adv    = out_ready || !w_valid[STAGES];
    assign in_ready = w_adv;

    assign w_valid[0] = in_valid;
    assign w_mode[0]  = in_mode;
    assign w_data[0]  = in_data;
    assign w_err[0]   = 1'b0;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_hi     = WIDTH - 1 - k * c_chunk;
            localparam int c_lo_raw = WIDTH - (k + 1) * c_chunk;
            localparam int c_lo     = (c_lo_raw < 0) ? 0 : c_lo_raw;

            gray_codec_stage #(
                .WIDTH     (WIDTH),
                .CHECK_BCD (CHECK_BCD),
                .FIRST     ((k == 0) ? 1 : 0),
                .LAST      ((k == STAGES - 1) ? 1 : 0),
                .SLICE_HI  (c_hi),
                .SLICE_LO  (c_lo)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .adv       (w_adv),
                .in_valid  (w_valid[k]),
                .in_mode   (w_mode[k]),
                .in_data   (w_data[k]),
                .in_err    (w_err[k]),
                .out_valid (w_valid[k+1]),
                .out_mode  (w_mode[k+1]),
                .out_data  (w_data[k+1]),
                .out_err   (w_err[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[STAGES];
    assign out_mode  = w_mode[STAGES];
    assign out_data  = w_data[STAGES];
    assign out_err   = w_err[STAGES];

endmodule
`default_nettype wire
